// File: rtl/jt12_cmdseq.sv
// Command-list sequencer that replays register writes, waits and flag polls onto JT12 CPU buses.
// Optional build macro JT12_CMDSEQ_RANDGAP_EN: LFSR-randomised inter-write gap.

module jt12_cmdseq #(
    parameter int  AW           = 10,
    parameter int  CSW          = 1,
    parameter int  BUSY_TIMEOUT = 500,
    parameter int  WAIT_SHIFT   = 8,
    localparam int CHIPS        = 2**CSW,
    localparam int DW           = 19 + CSW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ld_we,
    input  logic [AW-1:0]      ld_addr,
    input  logic [DW-1:0]      ld_data,
    input  logic [8*CHIPS-1:0] din,
    output logic [CHIPS-1:0]   cs_n,
    output logic               wr_n,
    output logic [1:0]         addr,
    output logic [7:0]         dout,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [AW-1:0]      cmd_ptr
);

    localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
    localparam int WCW = 8 + WAIT_SHIFT;

    typedef enum logic [3:0] {
        IDLE, FETCH, POLL, SETUP, STROBE, GAP, WAIT_CNT, DONE, ERR
    } state_t;

    typedef enum logic [1:0] {OP_END, OP_WAIT, OP_FLAG, OP_WRITE} op_t;

    typedef struct packed {
        op_t            op;
        logic [CSW-1:0] chip;
        logic           a1;
        logic [7:0]     rsel;
        logic [7:0]     val;
    } cmd_t;

    state_t         state, state_d;
    logic [AW-1:0]  ptr, ptr_d;
    logic           phase, phase_d;   // 0: register-select write, 1: data write
    logic [TW-1:0]  tmo, tmo_d;
    logic [WCW-1:0] wcnt, wcnt_d;
    logic           advance;
    logic           gap_over;
    cmd_t           cmd;
    logic [DW-1:0]  mem [2**AW];

    // NOTE: the command RAM and its read register are deliberately not reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (ld_we)
            mem[ld_addr] <= ld_data;
        if (state == FETCH)
            cmd <= mem[ptr];
    end

    logic [7:0] stat;
    logic       unused_stat;
    assign stat        = din[{cmd.chip, 3'b000} +: 8];
    assign unused_stat = ^stat[6:2];

`ifdef JT12_CMDSEQ_RANDGAP_EN
    logic [15:0] lfsr;
    logic [3:0]  gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= 16'hACE1;
            gap_cnt <= '0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (state == STROBE)
                gap_cnt <= lfsr[3:0];
            else if (state == GAP && !gap_over)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // Counts 0 and 1 both give one GAP cycle, so the bus always holds past the strobe.
    assign gap_over = (gap_cnt <= 4'd1);
`else
    assign gap_over = 1'b1;
`endif

    // NOTE: sequential state takes non-blocking assignments only; all decisions live in the always_comb below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            phase <= 1'b0;
            tmo   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            phase <= phase_d;
            tmo   <= tmo_d;
            wcnt  <= wcnt_d;
        end
    end

    // NOTE: every variable is given its default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        phase_d = phase;
        tmo_d   = tmo;
        wcnt_d  = wcnt;
        advance = 1'b0;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    ptr_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                phase_d = 1'b0;
                tmo_d   = TW'(BUSY_TIMEOUT);
                state_d = POLL;
            end
            POLL: begin
                if (stat[7]) begin
                    if (tmo <= TW'(1))
                        state_d = ERR;
                    else
                        tmo_d = tmo - TW'(1);
                end else begin
                    case (cmd.op)
                        OP_END:   state_d = DONE;
                        OP_WAIT: begin
                            wcnt_d  = {cmd.val, {WAIT_SHIFT{1'b0}}};
                            state_d = WAIT_CNT;
                        end
                        OP_FLAG:  advance = |(stat[1:0] & cmd.val[1:0]);
                        OP_WRITE: state_d = SETUP;
                    endcase
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = GAP;
            GAP: begin
                if (gap_over) begin
                    if (!phase) begin
                        // Re-poll BUSY between the register-select and data writes.
                        phase_d = 1'b1;
                        tmo_d   = TW'(BUSY_TIMEOUT);
                        state_d = POLL;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            WAIT_CNT: begin
                // A zero load still spends one cycle here; val<<WAIT_SHIFT otherwise gives that many cycles.
                if (wcnt <= WCW'(1))
                    advance = 1'b1;
                else
                    wcnt_d = wcnt - WCW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (&ptr) begin
                state_d = DONE;
            end else begin
                ptr_d   = ptr + AW'(1);
                state_d = FETCH;
            end
        end
    end

    logic bus_act;
    assign bus_act = (state == SETUP) || (state == STROBE) || (state == GAP);

    always_comb begin
        cs_n = '1;
        if (state == STROBE)
            cs_n[cmd.chip] = 1'b0;
    end

    assign wr_n        = (state != STROBE);
    assign addr        = bus_act ? {cmd.a1, phase} : 2'b00;
    assign dout        = bus_act ? (phase ? cmd.val : cmd.rsel) : 8'h00;
    assign busy        = !(state inside {IDLE, DONE, ERR});
    assign done        = (state == DONE);
    assign err_timeout = (state == ERR);
    assign cmd_ptr     = ptr;

endmodule

// File: tb/tb_jt12_cmdseq.sv
// Self-checking bench for jt12_cmdseq: directed timing cases plus random command lists
// checked against a transaction-level model of the expected bus writes.

module tb_jt12_cmdseq;

    localparam int AW  = 4;
    localparam int CSW = 1;
    localparam int TMO = 500;
    localparam int WS  = 8;
    localparam int DW  = 19 + CSW;
    localparam int N   = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [15:0]   din;
    logic [1:0]    cs_n;
    logic          wr_n;
    logic [1:0]    addr;
    logic [7:0]    dout;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic [AW-1:0] cmd_ptr;

    always #5 clk = ~clk;

    jt12_cmdseq #(
        .AW(AW), .CSW(CSW), .BUSY_TIMEOUT(TMO), .WAIT_SHIFT(WS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .din(din), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .dout(dout),
        .busy(busy), .done(done), .err_timeout(err_timeout), .cmd_ptr(cmd_ptr)
    );

    typedef struct packed {
        logic       wr_n;
        logic [1:0] cs_n;
        logic [1:0] addr;
        logic [7:0] dout;
        logic       done;
        logic       err;
    } snap_t;

    int          checks = 0;
    int          errors = 0;
    logic [DW-1:0] prog [N];
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    int          exp_ptr;
    snap_t       tr[$];      // tr[i] is the bus state after the i-th clock edge following start
    int          widx[$];    // trace indices of observed strobes

    logic        rnd_din = 1'b0;
    logic [15:0] din_dir = '0;
    logic [15:0] din_rnd = '0;
    assign din = rnd_din ? din_rnd : din_dir;

    initial forever begin
        @(negedge clk);
        din_rnd = {($urandom_range(0, 3) == 0), 5'b0, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 5'b0, 2'($urandom_range(0, 3))};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] cmdw(input int op, input int chip, input int a1,
                                           input int r, input int v);
        return {op[1:0], chip[0], a1[0], r[7:0], v[7:0]};
    endfunction

    function automatic logic [11:0] wrec(input logic chip, input logic [1:0] a, input logic [7:0] d);
        return {(chip ? 2'b01 : 2'b10), a, d};
    endfunction

    function automatic int wi(input int k);
        return (k < widx.size()) ? widx[k] : -1;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < N; i++) prog[i] = '0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_data = prog[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Walks the list as the command set defines it: only WRITE produces bus traffic.
    task automatic model();
        exp_q.delete();
        exp_ptr = N - 1;
        for (int i = 0; i < N; i++) begin
            logic [1:0] op;
            logic       chip, a1;
            logic [7:0] r, v;
            {op, chip, a1, r, v} = prog[i];
            if (op == 2'd0) begin
                exp_ptr = i;
                break;
            end
            if (op == 2'd3) begin
                exp_q.push_back(wrec(chip, {a1, 1'b0}, r));
                exp_q.push_back(wrec(chip, {a1, 1'b1}, v));
            end
        end
    endtask

    task automatic run_seq(input int limit);
        bit fin;
        tr.delete();
        widx.delete();
        got_q.delete();
        fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin) begin
            tr.push_back('{wr_n, cs_n, addr, dout, done, err_timeout});
            if (!wr_n) begin
                widx.push_back(tr.size() - 1);
                got_q.push_back({cs_n, addr, dout});
            end
            if (done || err_timeout) begin
                fin = 1'b1;
            end else if (tr.size() >= limit) begin
                check("run_limit", 0, 1);
                fin = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic check_bus(input string tag);
        int bad = 0;
        foreach (tr[i]) begin
            if (tr[i].wr_n) begin
                if (tr[i].cs_n !== 2'b11) bad++;
            end else begin
                if ($countones(~tr[i].cs_n) != 1) bad++;
                if (i == 0 || i + 1 >= tr.size()) bad++;
                else if (tr[i-1].addr !== tr[i].addr || tr[i-1].dout !== tr[i].dout ||
                         tr[i+1].addr !== tr[i].addr || tr[i+1].dout !== tr[i].dout) bad++;
            end
        end
        check({tag, "_bus"}, bad, 0);
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic check_end(input string tag);
        check({tag, "_done"}, tr[tr.size()-1].done, 1);
        check({tag, "_err"},  tr[tr.size()-1].err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ptr"},  cmd_ptr, exp_ptr);
    endtask

    initial begin
        int k;
        int bad;
        rst_n   = 1'b0;
        start   = 1'b0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        #13;
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_wr_n", wr_n, 1);
        check("rst_addr", addr, 0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err",  err_timeout, 0);
        check("rst_ptr",  cmd_ptr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Single write: strobe after start, FETCH, POLL, SETUP; 9 cycles per write command.
        clear_prog();
        prog[0] = cmdw(3, 0, 0, 'h28, 'hF0);
        load_prog();
        model();
        run_seq(200);
        check_bus("t1");
        check("t1_strobe0", wi(0), 3);
        check("t1_strobe1", wi(1), 7);
        check("t1_done_at", tr.size() - 1, 11);
        check_end("t1");

        // BUSY held 100 cycles from the register-select strobe: the data strobe follows
        // two edges after BUSY is first seen low (POLL, SETUP, STROBE).
        fork
            run_seq(400);
            begin
                k = 0;
                while (wr_n !== 1'b0 && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                din_dir[7] = 1'b1;
                repeat (100) @(negedge clk);
                din_dir[7] = 1'b0;
            end
        join
        check_bus("t2");
        check("t2_stall", wi(1) - wi(0), 102);
        check_end("t2");

        // Permanent BUSY: 500 POLL cycles after FETCH, ERR on the next edge.
        din_dir = 16'h0080;
        run_seq(800);
        check("t3_err_at", tr.size() - 1, 1 + TMO);
        check("t3_err",    tr[tr.size()-1].err, 1);
        check("t3_done",   tr[tr.size()-1].done, 0);
        check("t3_busy",   busy, 0);
        check("t3_nwr",    got_q.size(), 0);
        din_dir = '0;
        run_seq(200);
        check("t3_err_clr", tr[0].err, 0);
        check_bus("t3r");
        check_end("t3r");

        // WAIT lasts max(1, val<<WS) cycles between POLL and the next FETCH.
        for (int v = 0; v < 3; v++) begin
            clear_prog();
            prog[0] = cmdw(1, 0, 0, 0, v);
            load_prog();
            model();
            run_seq(1000);
            check($sformatf("t4_v%0d_done_at", v), tr.size() - 1, 4 + ((v == 0) ? 1 : (v << WS)));
            check_end($sformatf("t4_v%0d", v));
        end

        // FLAG on chip 1 mask 2: chip 0's flag and chip 1's unmasked flag must not release it.
        clear_prog();
        prog[0] = cmdw(2, 1, 0, 0, 2);
        prog[1] = cmdw(3, 1, 1, 'h30, 'h7F);
        load_prog();
        model();
        din_dir = 16'h0102;
        fork
            run_seq(400);
            begin
                repeat (52) @(negedge clk);   // negedge where trace index 50 is sampled
                din_dir[9] = 1'b1;
            end
        join
        check("t5_strobe0", wi(0), 54);
        check_bus("t5");
        check_end("t5");
        din_dir = '0;

        // Full RAM of writes: no wrap, ends on the last address.
        for (int i = 0; i < N; i++)
            prog[i] = cmdw(3, $urandom_range(0, 1), $urandom_range(0, 1),
                           $urandom_range(0, 255), $urandom_range(0, 255));
        load_prog();
        model();
        run_seq(400);
        check_bus("t6");
        check("t6_done_at", tr.size() - 1, 9 * N);
        bad = 0;
        for (int j = 1; j < widx.size(); j++)
            if (widx[j] - widx[j-1] != ((j % 2 == 1) ? 4 : 5)) bad++;
        check("t6_spacing", bad, 0);
        check_end("t6");

        // Random command lists with random BUSY bursts and flag activity.
        rnd_din = 1'b1;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < N; i++) begin
                int p;
                p = $urandom_range(0, 99);
                if (p < 8)       prog[i] = cmdw(0, 0, 0, 0, 0);
                else if (p < 20) prog[i] = cmdw(1, $urandom_range(0, 1), 0, 0, $urandom_range(0, 1));
                else if (p < 35) prog[i] = cmdw(2, $urandom_range(0, 1), 0, 0,
                                                ($urandom_range(0, 63) << 2) | $urandom_range(1, 3));
                else             prog[i] = cmdw(3, $urandom_range(0, 1), $urandom_range(0, 1),
                                                $urandom_range(0, 255), $urandom_range(0, 255));
            end
            load_prog();
            model();
            run_seq(20000);
            check_bus($sformatf("r%0d", it));
            check_end($sformatf("r%0d", it));
        end
        rnd_din = 1'b0;

        // Asynchronous reset while the strobe is active releases the bus at once.
        clear_prog();
        prog[0] = cmdw(3, 0, 0, 'h28, 'hF0);
        load_prog();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (wr_n !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_seen", wr_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_n", wr_n, 1);
        check("rst_mid_cs_n", cs_n, 2'b11);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
